// File: rtl/twos_conv_pkg.sv
// Shared definitions for the two's-complement encoder/decoder pair.
package twos_conv_pkg;

  localparam int unsigned DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Most-negative two's-complement pattern of width w, right-aligned in 32 bits.
  function automatic logic [31:0] min_neg(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// One-bit serial negator: copies bits up to and including the first one, then
// inverts the rest when neg is set.
module serial_negate_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic neg,
  input  logic bit_in,
  output logic bit_out
);

  logic r_seen_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_one <= 1'b0;
    end else if (clr) begin
      r_seen_one <= 1'b0;
    end else if (en) begin
      r_seen_one <= r_seen_one | bit_in;
    end
  end

  assign bit_out = neg ? (bit_in ^ r_seen_one) : bit_in;

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder with valid/ready on
// both sides; one operand bit is processed per clock, LSB first.
module twos_to_signmag_serial
  import twos_conv_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [W-1:0] out_mag,
  output logic         out_min_neg,
  output logic         busy
);

  localparam int unsigned   CW      = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [W-1:0]  MIN_NEG = W'(min_neg(W));

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_sh;
  logic [W-1:0]  r_mag;
  logic [CW-1:0] r_cnt;
  logic          r_sign;
  logic          r_min_neg;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_accept;
  logic          w_conv;
  logic          w_bit_out;

  // r_in_ready is only ever set while in IDLE, so it doubles as the IDLE qualifier.
  assign w_accept = r_in_ready & in_valid;
  assign w_conv   = (r_state == CONV);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)         w_state_nxt = CONV;
      CONV:    if (r_cnt == LAST)    w_state_nxt = DONE;
      DONE:    if (out_ready)        w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they stay low in reset
  // and never depend combinationally on the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh      <= '0;
      r_mag     <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_min_neg <= 1'b0;
    end else if (w_accept) begin
      r_sh      <= in_data;
      r_sign    <= in_data[W-1];
      r_cnt     <= '0;
      r_min_neg <= (in_data == MIN_NEG);
    end else if (w_conv) begin
      r_sh  <= r_sh >> 1;
      r_mag <= {w_bit_out, r_mag[W-1:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  serial_negate_cell u_neg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_accept),
    .en      (w_conv),
    .neg     (r_sign),
    .bit_in  (r_sh[0]),
    .bit_out (w_bit_out)
  );

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_sign    = r_sign;
  assign out_mag     = r_mag;
  assign out_min_neg = r_min_neg;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Scoreboard bench for twos_to_signmag_serial: directed corner words,
// backpressure, mid-conversion reset and a randomized stream.
module tb_twos_to_signmag_serial;

  localparam int unsigned W = 8;
  localparam int unsigned N = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_min_neg;
  logic         busy;

  typedef struct {
    logic         s;
    logic [W-1:0] m;
    logic         mn;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   rcvd = 0;

  twos_to_signmag_serial #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_mag     (out_mag),
    .out_min_neg (out_min_neg),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference: interpret the word as a signed integer and take its absolute value.
  function automatic exp_t model(input logic [W-1:0] x);
    longint v;
    exp_t   e;
    v    = longint'($signed(x));
    e.s  = (v < 0);
    e.m  = W'((v < 0) ? -v : v);
    e.mn = (v == -(longint'(1) << (W - 1)));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) q.push_back(model(in_data));
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      rcvd++;
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got mag %0h with empty scoreboard at %0t", out_mag, $time);
      end else begin
        e = q.pop_front();
        check("sb_sign", out_sign, e.s);
        check("sb_mag", out_mag, e.m);
        check("sb_min_neg", out_min_neg, e.mn);
      end
    end
  end

  // Entered and left at posedge+1; out_ready is held high throughout.
  task automatic send_dir(input logic [W-1:0] x, input logic es, input logic [W-1:0] em,
                          input logic emn);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL dir_accept_timeout: in_ready stuck 0 for word %0h", x);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (W - 1) @(posedge clk);
    #1;
    check("lat_not_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1'b1);
    check("dir_sign", out_sign, es);
    check("dir_mag", out_mag, em);
    check("dir_min_neg", out_min_neg, emn);
    @(posedge clk); #1;
    check("ready_after_hs", in_ready, 1'b1);
    check("valid_after_hs", out_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] sp [5];
    logic         hold_s;
    logic [W-1:0] hold_m;
    logic         acc;
    int           sent;
    int           cyc;
    int           target;
    int           n;

    sp = '{8'h80, 8'h00, 8'h7F, 8'hFF, 8'h01};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_mag", out_mag, '0);
    check("rst_out_sign", out_sign, 1'b0);
    check("rst_min_neg", out_min_neg, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    check("in_ready_first_edge", in_ready, 1'b1);

    send_dir(8'h05, 1'b0, 8'h05, 1'b0);
    send_dir(8'hFA, 1'b1, 8'h06, 1'b0);
    send_dir(8'hFF, 1'b1, 8'h01, 1'b0);
    send_dir(8'h80, 1'b1, 8'h80, 1'b1);
    send_dir(8'h00, 1'b0, 8'h00, 1'b0);
    send_dir(8'h7F, 1'b0, 8'h7F, 1'b0);

    // Backpressure: result must hold while out_ready is low and new words are refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hC3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", out_valid, 1'b1);
    hold_s = out_sign;
    hold_m = out_mag;
    check("bp_mag", hold_m, 8'h3D);
    check("bp_sign", hold_s, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11;
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_mag", out_mag, hold_m);
      check("bp_hold_sign", out_sign, hold_s);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_busy", busy, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_valid", out_valid, 1'b0);

    // Reset three bits into a conversion.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_mag", out_mag, '0);
    check("mid_rst_sign", out_sign, 1'b0);
    check("mid_rst_min_neg", out_min_neg, 1'b0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1'b1);
    send_dir(8'hF0, 1'b1, 8'h10, 1'b0);

    // Random streaming with gaps on both handshakes.
    target = rcvd + N;
    sent   = 0;
    cyc    = 0;
    acc    = 1'b0;
    while ((sent < N || rcvd < target) && cyc < 60000) begin
      @(posedge clk);
      if (acc) sent++;
      #1;
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        if ($urandom_range(0, 7) == 0) in_data = sp[$urandom_range(0, 4)];
        else                           in_data = W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 3) @(posedge clk);
    #1;
    check("stream_sent", sent, N);
    check("stream_rcvd", rcvd, target);
    check("stream_sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
